fec_deserializer: RTL and testbench
===================================

FEC_DESERIALIZER -- requirements
Module: fec_deserializer

Interface
REQ-001 Param SERIAL_DATA_WIDTH, default 10, bits per received word.
REQ-002 Param SERIAL_DATA_DEPTH, default 8, words per frame.
REQ-003 Param SERIAL_DIV_WIDTH, default 16, width of the bit-period divider.
REQ-004 Param DL_PREAMBLE_COUNT, default 4, number of preamble '1' bits.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 en  input  1  receiver enable; low aborts any frame.
REQ-008 clk_div  input  SERIAL_DIV_WIDTH  bit period in clk cycles.
REQ-009 ser_in  input  1  asynchronous serial line; idles low.
REQ-010 word_data  output  SERIAL_DATA_WIDTH  received word, MSB first on the line.
REQ-011 word_idx  output  $clog2(SERIAL_DATA_DEPTH)  word position in the frame.
REQ-012 word_valid  output  1  word_data/word_idx valid.
REQ-013 word_ready  input  1  consumer accepts the word when word_valid is high.
REQ-014 frame_done  output  1  one-cycle pulse after the last word is captured.
REQ-015 err_preamble  output  1  one-cycle pulse on a preamble/sync violation.
REQ-016 overrun  output  1  sticky; a word was overwritten while unaccepted.
REQ-017 overrun_clr  input  1  synchronous clear of overrun.

Function
REQ-018 Frame format SHALL be DL_PREAMBLE_COUNT '1' bits, one '0' sync bit, then SERIAL_DATA_DEPTH words of SERIAL_DATA_WIDTH bits each, MSB first.
REQ-019 ser_in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (ser_s).
REQ-020 States SHALL be IDLE, PREAMBLE, SYNC, DATA.
REQ-021 IDLE->PREAMBLE on a ser_s 0->1 transition with en=1: clear phase and bit counters, latch eff_div = max(clk_div,2).
REQ-022 The phase counter SHALL count 0..eff_div-1 and wrap; the bit is sampled when phase == eff_div>>1.
REQ-023 PREAMBLE: each sample SHALL be 1; after DL_PREAMBLE_COUNT samples of 1, go to SYNC.
REQ-024 A 0 sampled in PREAMBLE, or a 1 sampled in SYNC, SHALL pulse err_preamble for one cycle and return to IDLE.
REQ-025 SYNC sample 0 -> DATA with bit count 0 and word count 0.
REQ-026 DATA: each sample is shifted into the shift register LSB-side, so the first bit ends in the MSB.
REQ-027 On the SERIAL_DATA_WIDTH-th sample, on the next clk: word_data = shift register, word_idx = word count, word_valid = 1, word count +1.
REQ-028 After word SERIAL_DATA_DEPTH-1 is loaded: frame_done pulses in the same cycle as that word_valid assertion; FSM returns to IDLE.
REQ-029 word_valid SHALL clear on the cycle after word_valid && word_ready, unless a new word loads in that cycle.
REQ-030 New word load with word_valid=1 and word_ready=0 SHALL overwrite word_data/word_idx and set overrun.
REQ-031 New word load in the same cycle as word_valid && word_ready SHALL load the new word, keep word_valid=1, and leave overrun unchanged.
REQ-032 overrun_clr SHALL clear overrun, except when a new overrun occurs in the same cycle; set wins.
REQ-033 en=0 SHALL force IDLE next cycle and clear counters, with no err/frame_done pulse; a pending word_valid is kept.
REQ-034 clk_div changes mid-frame SHALL be ignored until the next frame start.

Reset
REQ-035 rst_n=0 SHALL asynchronously set state=IDLE, all counters/shift register/synchronizer=0, and word_data=0, word_idx=0, word_valid=0, frame_done=0, err_preamble=0, overrun=0.
REQ-036 After rst_n deasserts mid-line-activity, the block SHALL wait for a fresh ser_s 0->1 edge before starting a frame.

Verification
REQ-037 Happy path: clk_div=7, word_ready=1, words 0x3FF,0x000,0x2AA,0x155,0x001,0x200,0x0F0,0x30F -> 8 word_valid pulses with those values, idx 0..7, frame_done with idx 7, no errors.
REQ-038 Bad preamble: clk_div=7, line 1,1,0 -> err_preamble pulse at the third sample, FSM back to IDLE, no word_valid.
REQ-039 Backpressure: word_ready=0 for the whole frame -> word_data=0x30F, idx=7, overrun=1; overrun_clr pulse -> overrun=0.
REQ-040 Divider clamp: clk_div=0 and clk_div=1 with a 2-cycle bit period -> frame received correctly.
REQ-041 Abort: en dropped after word 3 -> IDLE, no frame_done; a following full frame is received correctly from idx 0.
REQ-042 Reset mid-frame: rst_n pulsed during word 5 -> all outputs 0; the next frame is received correctly.

Source files
------------

// File: rtl/fec_deserializer.sv
// Serial frame receiver: preamble/sync detection, mid-bit sampling and word
// assembly with a single-entry valid/ready output holding register.
//
// state    | meaning
// IDLE     | waiting for a ser_s 0->1 edge with en high
// PREAMBLE | sampling DL_PREAMBLE_COUNT '1' bits
// SYNC     | expecting the single '0' sync bit
// DATA     | shifting in SERIAL_DATA_DEPTH words, MSB first
module fec_deserializer #(
    parameter int SERIAL_DATA_WIDTH = 10,
    parameter int SERIAL_DATA_DEPTH = 8,
    parameter int SERIAL_DIV_WIDTH  = 16,
    parameter int DL_PREAMBLE_COUNT = 4,
    localparam int IDX_W = (SERIAL_DATA_DEPTH > 1) ? $clog2(SERIAL_DATA_DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [SERIAL_DIV_WIDTH-1:0]  clk_div,
    input  logic                         ser_in,
    output logic [SERIAL_DATA_WIDTH-1:0] word_data,
    output logic [IDX_W-1:0]             word_idx,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic                         frame_done,
    output logic                         err_preamble,
    output logic                         overrun,
    input  logic                         overrun_clr
);
    localparam int W      = SERIAL_DATA_WIDTH;
    localparam int DIV_W  = SERIAL_DIV_WIDTH;
    localparam int CNT_MX = (W > DL_PREAMBLE_COUNT) ? W : DL_PREAMBLE_COUNT;
    localparam int CNT_W  = $clog2(CNT_MX + 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, SYNC, DATA} state_t;

    state_t           state_q, state_d;
    logic             ser_m_q, ser_s_q, ser_prev_q;
    logic [DIV_W-1:0] phase_q, phase_d, eff_div_q, eff_div_d, phase_nxt;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0] word_cnt_q, word_cnt_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [W-1:0]     word_data_q, word_data_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic             word_valid_q, word_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             err_q, err_d;
    logic             overrun_q, overrun_d;
    logic             sample, load;

    assign sample    = (phase_q == (eff_div_q >> 1));
    assign phase_nxt = (phase_q == eff_div_q - DIV_W'(1)) ? '0 : phase_q + DIV_W'(1);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        eff_div_d    = eff_div_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        shift_d      = shift_q;
        word_data_d  = word_data_q;
        word_idx_d   = word_idx_q;
        word_valid_d = word_valid_q;
        overrun_d    = overrun_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        load         = 1'b0;

        if (!en) begin
            state_d    = IDLE;
            phase_d    = '0;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ser_s_q && !ser_prev_q) begin
                        state_d    = PREAMBLE;
                        // The edge-detect cycle is already phase 0 of the first bit.
                        phase_d    = DIV_W'(1);
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                        eff_div_d  = (clk_div < DIV_W'(2)) ? DIV_W'(2) : clk_div;
                    end
                end
                PREAMBLE: begin
                    phase_d = phase_nxt;
                    if (sample) begin
                        if (!ser_s_q) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else if (bit_cnt_q == CNT_W'(DL_PREAMBLE_COUNT - 1)) begin
                            state_d   = SYNC;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                SYNC: begin
                    phase_d = phase_nxt;
                    if (sample) begin
                        if (ser_s_q) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d    = DATA;
                            bit_cnt_d  = '0;
                            word_cnt_d = '0;
                        end
                    end
                end
                DATA: begin
                    phase_d = phase_nxt;
                    if (sample) begin
                        shift_d = {shift_q[W-2:0], ser_s_q};
                        if (bit_cnt_q == CNT_W'(W - 1)) begin
                            load       = 1'b1;
                            bit_cnt_d  = '0;
                            word_cnt_d = word_cnt_q + IDX_W'(1);
                            if (word_cnt_q == IDX_W'(SERIAL_DATA_DEPTH - 1)) begin
                                frame_done_d = 1'b1;
                                state_d      = IDLE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (load) begin
            word_data_d  = shift_d;
            word_idx_d   = word_cnt_q;
            word_valid_d = 1'b1;
        end else if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end

        // A fresh overrun beats a simultaneous clear.
        if (load && word_valid_q && !word_ready) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ser_m_q      <= 1'b0;
            ser_s_q      <= 1'b0;
            ser_prev_q   <= 1'b0;
            phase_q      <= '0;
            eff_div_q    <= DIV_W'(2);
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            shift_q      <= '0;
            word_data_q  <= '0;
            word_idx_q   <= '0;
            word_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ser_m_q      <= ser_in;
            ser_s_q      <= ser_m_q;
            ser_prev_q   <= ser_s_q;
            phase_q      <= phase_d;
            eff_div_q    <= eff_div_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            shift_q      <= shift_d;
            word_data_q  <= word_data_d;
            word_idx_q   <= word_idx_d;
            word_valid_q <= word_valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign word_data    = word_data_q;
    assign word_idx     = word_idx_q;
    assign word_valid   = word_valid_q;
    assign frame_done   = frame_done_q;
    assign err_preamble = err_q;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_fec_deserializer.sv
// Directed and randomized frame scenarios for fec_deserializer, checked against
// the word lists the bench itself transmits.
module tb_fec_deserializer;
    typedef logic [9:0] frame_t [8];
    typedef bit bitq_t [$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] clk_div = 16'd7;
    logic        ser_in = 1'b0;
    logic [9:0]  word_data;
    logic [2:0]  word_idx;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic        frame_done;
    logic        err_preamble;
    logic        overrun;
    logic        overrun_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] cap_data [$];
    int         cap_idx  [$];
    int         done_cnt = 0;
    int         done_idx = -1;
    int         err_cnt  = 0;

    fec_deserializer dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clk_div(clk_div), .ser_in(ser_in),
        .word_data(word_data), .word_idx(word_idx), .word_valid(word_valid),
        .word_ready(word_ready), .frame_done(frame_done), .err_preamble(err_preamble),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (word_valid && word_ready) begin
                cap_data.push_back(word_data);
                cap_idx.push_back(int'(word_idx));
            end
            if (frame_done) begin
                done_cnt++;
                done_idx = word_valid ? int'(word_idx) : -1;
            end
            if (err_preamble) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        cap_data.delete();
        cap_idx.delete();
        done_cnt = 0;
        done_idx = -1;
        err_cnt  = 0;
    endtask

    // Line image of a frame: 4 preamble ones, sync zero, 8 words MSB first.
    function automatic bitq_t frame_bits(input frame_t w);
        bitq_t q;
        for (int i = 0; i < 4; i++) q.push_back(1'b1);
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int b = 9; b >= 0; b--) q.push_back(w[i][b]);
        return q;
    endfunction

    task automatic send_seq(input bitq_t q, input int period, input int first, input int last);
        for (int i = first; i < last && i < q.size(); i++) begin
            ser_in = q[i];
            repeat (period) @(negedge clk);
        end
    endtask

    task automatic send_frame(input frame_t w, input int period);
        send_seq(frame_bits(w), period, 0, 1000);
        ser_in = 1'b0;
        idle(4 * period + 10);
    endtask

    task automatic check_words(input string tag, input frame_t w, input int n_exp, input int exp_done);
        check({tag, " nwords"}, cap_data.size(), n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (i < cap_data.size()) begin
                check($sformatf("%s data%0d", tag, i), 32'(cap_data[i]), 32'(w[i]));
                check($sformatf("%s idx%0d", tag, i), cap_idx[i], i);
            end
        end
        check({tag, " done_cnt"}, done_cnt, exp_done);
        if (exp_done > 0) check({tag, " done_idx"}, done_idx, 7);
        check({tag, " err_cnt"}, err_cnt, 0);
    endtask

    task automatic random_frame(output frame_t w);
        for (int i = 0; i < 8; i++) w[i] = 10'($urandom);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " word_valid"}, 32'(word_valid), 0);
        check({tag, " word_data"}, 32'(word_data), 0);
        check({tag, " word_idx"}, 32'(word_idx), 0);
        check({tag, " frame_done"}, 32'(frame_done), 0);
        check({tag, " err_preamble"}, 32'(err_preamble), 0);
        check({tag, " overrun"}, 32'(overrun), 0);
    endtask

    initial begin
        frame_t hp;
        frame_t w;
        bitq_t  q;
        int     period;

        hp = '{10'h3FF, 10'h000, 10'h2AA, 10'h155, 10'h001, 10'h200, 10'h0F0, 10'h30F};

        idle(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        en    = 1'b1;
        idle(5);

        clk_div = 16'd7;
        clear_mon();
        send_frame(hp, 7);
        check_words("happy", hp, 8, 1);
        check("happy overrun", 32'(overrun), 0);

        for (int r = 0; r < 3; r++) begin
            period  = int'($urandom_range(2, 9));
            clk_div = 16'(period);
            random_frame(w);
            clear_mon();
            send_frame(w, period);
            check_words($sformatf("rand%0d div%0d", r, period), w, 8, 1);
        end

        clk_div = 16'd7;
        clear_mon();
        q = '{1'b1, 1'b1, 1'b0};
        send_seq(q, 7, 0, 3);
        ser_in = 1'b0;
        idle(30);
        check("badpre err_cnt", err_cnt, 1);
        check("badpre nwords", cap_data.size(), 0);
        check("badpre word_valid", 32'(word_valid), 0);

        clear_mon();
        q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        send_seq(q, 7, 0, 5);
        ser_in = 1'b0;
        idle(30);
        check("badsync err_cnt", err_cnt, 1);
        check("badsync nwords", cap_data.size(), 0);

        clear_mon();
        random_frame(w);
        send_frame(w, 7);
        check_words("after_err", w, 8, 1);

        for (int d = 0; d < 2; d++) begin
            clk_div = 16'(d);
            random_frame(w);
            clear_mon();
            send_frame(w, 2);
            check_words($sformatf("clamp div%0d", d), w, 8, 1);
        end

        clk_div = 16'd7;
        random_frame(w);
        clear_mon();
        q = frame_bits(w);
        send_seq(q, 7, 0, 8);
        clk_div = 16'd3;
        send_seq(q, 7, 8, 1000);
        ser_in = 1'b0;
        idle(40);
        check_words("divchange", w, 8, 1);

        clk_div = 16'd7;
        random_frame(w);
        clear_mon();
        send_seq(frame_bits(w), 7, 0, 48);
        en     = 1'b0;
        ser_in = 1'b0;
        idle(30);
        check_words("abort", w, 4, 0);
        en = 1'b1;
        idle(5);
        random_frame(w);
        clear_mon();
        send_frame(w, 7);
        check_words("post_abort", w, 8, 1);

        word_ready = 1'b0;
        clear_mon();
        send_frame(hp, 7);
        check("bp word_valid", 32'(word_valid), 1);
        check("bp word_data", 32'(word_data), 32'h30F);
        check("bp word_idx", 32'(word_idx), 7);
        check("bp overrun", 32'(overrun), 1);
        check("bp done_cnt", done_cnt, 1);
        overrun_clr = 1'b1;
        idle(1);
        overrun_clr = 1'b0;
        idle(1);
        check("bp overrun_clr", 32'(overrun), 0);
        check("bp valid_held", 32'(word_valid), 1);
        word_ready = 1'b1;
        idle(2);
        check("bp drained", 32'(word_valid), 0);

        word_ready = 1'b0;
        random_frame(w);
        clear_mon();
        send_seq(frame_bits(w), 7, 0, 59);
        check("rst pre valid", 32'(word_valid), 1);
        rst_n  = 1'b0;
        ser_in = 1'b0;
        #1;
        check_outputs_zero("midreset");
        idle(3);
        rst_n      = 1'b1;
        word_ready = 1'b1;
        idle(10);
        random_frame(w);
        clear_mon();
        send_frame(w, 7);
        check_words("post_reset", w, 8, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
